// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - button synchronizer, debouncer and auto-repeat event generator
module button_ctrl #(
    parameter int N            = 4,
    parameter int TICK_DIV     = 1024,
    parameter int DEB_SAMPLES  = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [N-1:0] btn_in,
    input  logic         rep_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,      // release event; "release" is a reserved word
    output logic         tick
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int DW   = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_SAMPLES - 1);
    localparam logic [RW-1:0] DLY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rstate_t;

    logic [N-1:0]  s1;
    logic [N-1:0]  s;
    logic [PW-1:0] pcnt;
    logic          tick_i;

    logic [DW-1:0] dcnt   [N];
    logic [DW-1:0] dcnt_n [N];
    logic [RW-1:0] rcnt   [N];
    logic [RW-1:0] rcnt_n [N];
    rstate_t       st     [N];
    rstate_t       st_n   [N];

    logic [N-1:0]  level_n;
    logic [N-1:0]  press_n;
    logic [N-1:0]  rel_n;

    assign tick_i = (pcnt == TICK_MAX);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            s1    <= '0;
            s     <= '0;
            pcnt  <= '0;
            tick  <= 1'b0;
            level <= '0;
            press <= '0;
            rel   <= '0;
            for (int i = 0; i < N; i++) begin
                dcnt[i] <= '0;
                rcnt[i] <= '0;
                st[i]   <= IDLE;
            end
        end else begin
            s1    <= btn_in;
            s     <= s1;
            pcnt  <= tick_i ? '0 : pcnt + 1'b1;
            tick  <= tick_i;
            level <= level_n;
            press <= press_n;
            rel   <= rel_n;
            for (int i = 0; i < N; i++) begin
                dcnt[i] <= dcnt_n[i];
                rcnt[i] <= rcnt_n[i];
                st[i]   <= st_n[i];
            end
        end
    end

    always_comb begin
        logic rise;
        logic fall;
        level_n = level;
        press_n = '0;
        rel_n   = '0;
        for (int i = 0; i < N; i++) begin
            rise      = 1'b0;
            fall      = 1'b0;
            dcnt_n[i] = dcnt[i];
            rcnt_n[i] = rcnt[i];
            st_n[i]   = st[i];

            if (tick_i) begin
                if (s[i] != level[i]) begin
                    if (dcnt[i] == DEB_MAX) begin
                        level_n[i] = s[i];
                        dcnt_n[i]  = '0;
                        rise       = s[i];
                        fall       = ~s[i];
                    end else begin
                        dcnt_n[i] = dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt_n[i] = '0;
                end
            end

            press_n[i] = rise;
            rel_n[i]   = fall;

            // A fall wins over a repeat due on the same tick; counters saturate while rep_en is low.
            case (st[i])
                IDLE: begin
                    if (rise) begin
                        st_n[i]   = HOLD;
                        rcnt_n[i] = '0;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        st_n[i]   = IDLE;
                        rcnt_n[i] = '0;
                    end else if (tick_i) begin
                        if (rcnt[i] == DLY_MAX) begin
                            if (rep_en) begin
                                press_n[i] = 1'b1;
                                st_n[i]    = REPEAT;
                                rcnt_n[i]  = '0;
                            end
                        end else begin
                            rcnt_n[i] = rcnt[i] + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        st_n[i]   = IDLE;
                        rcnt_n[i] = '0;
                    end else if (tick_i) begin
                        if (rcnt[i] == RATE_MAX) begin
                            if (rep_en) begin
                                press_n[i] = 1'b1;
                                rcnt_n[i]  = '0;
                            end
                        end else begin
                            rcnt_n[i] = rcnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    st_n[i]   = IDLE;
                    rcnt_n[i] = '0;
                end
            endcase
        end
    end

endmodule
